msp430_ctrl_seq: RTL and testbench

- Multi-cycle control sequencer for the MSP430x2xx datapath.
- Fetches the instruction word and the optional immediate extension word through a req/ack memory handshake.
- Decodes format I, format II and jump instructions, then drives register-file addresses, ALU opcode, write/flag enables and PC controls.
- Exposes its state code on Fsm for debug; traps on unsupported encodings or memory timeout.

---
 rtl/msp430_ctrl_seq_if.sv | 10 +
 rtl/msp430_ctrl_seq.sv | 210 +++++++++++++++++++++
 tb/tb_msp430_ctrl_seq.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msp430_ctrl_seq_if.sv
// Instruction-memory read handshake between the control sequencer and memory.
// master: sequencer side (drives Mem_req); slave: memory side (drives data and ack).
interface msp430_ctrl_seq_if;
    logic        Mem_req;
    logic [15:0] Mem_rdata;
    logic        Mem_ack;

    modport master (output Mem_req, input Mem_rdata, input Mem_ack);
    modport slave  (input Mem_req, output Mem_rdata, output Mem_ack);
endinterface

// File: rtl/msp430_ctrl_seq.sv
// Multi-cycle fetch/decode/execute control sequencer for an MSP430x2xx datapath.
// Optional SINGLE_STEP_EN adds a Step input and a STEP_WAIT hold state after each retire.
module msp430_ctrl_seq #(
    parameter int unsigned FSM_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               Clk,
    input  logic               Rst,
`ifdef SINGLE_STEP_EN
    input  logic               Step,
`endif
    msp430_ctrl_seq_if.master  mem,
    input  logic [3:0]         Flags,
    output logic [15:0]        Instr,
    output logic [15:0]        Instr_1,
    output logic [3:0]         Src_reg_out,
    output logic [3:0]         Dst_reg_out,
    output logic [3:0]         Alu_op,
    output logic               Bw,
    output logic               Imm_sel,
    output logic               Wr_en_out,
    output logic               Flags_wr,
    output logic               PC_inc_out,
    output logic               PC_load,
    output logic [9:0]         PC_offset_out,
    output logic               Trap,
    output logic [FSM_W-1:0]   Fsm
);
    localparam int unsigned      CNT_W     = 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        EXT       = 4'd3,
        EXEC      = 4'd4,
        WB        = 4'd5,
        JUMP      = 4'd6,
        TRAP      = 4'd7,
        STEP_WAIT = 4'd8
    } state_t;

`ifdef SINGLE_STEP_EN
    localparam state_t RETIRE = STEP_WAIT;
`else
    localparam state_t RETIRE = FETCH;
`endif

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic       is_jump;
    logic       dec_legal;
    logic       dec_imm;
    logic [3:0] dec_src;
    logic [3:0] dec_dst;
    logic [3:0] dec_alu;
    logic       jump_taken;
    logic       wb_wr;
    logic       wb_flags;

    // Instruction decode from the latched instruction word
    always_comb begin
        is_jump   = (Instr[15:13] == 3'b001);
        dec_legal = 1'b0;
        dec_imm   = 1'b0;
        dec_src   = 4'h0;
        dec_dst   = 4'h0;
        dec_alu   = 4'h0;
        if (Instr[15:12] >= 4'h4) begin
            dec_src   = Instr[11:8];
            dec_dst   = Instr[3:0];
            dec_alu   = Instr[15:12];
            dec_imm   = (Instr[5:4] == 2'b11) && (Instr[11:8] == 4'h0);
            dec_legal = !Instr[7] && ((Instr[5:4] == 2'b00) || dec_imm);
        end else if (Instr[15:10] == 6'b000100) begin
            dec_src   = Instr[3:0];
            dec_dst   = Instr[3:0];
            dec_alu   = {2'b00, Instr[8:7]};
            dec_legal = !Instr[9] && (Instr[5:4] == 2'b00);
        end
    end

    // Jump condition on {V,N,Z,C}
    always_comb begin
        jump_taken = 1'b0;
        case (Instr[12:10])
            3'b000:  jump_taken = !Flags[1];
            3'b001:  jump_taken =  Flags[1];
            3'b010:  jump_taken = !Flags[0];
            3'b011:  jump_taken =  Flags[0];
            3'b100:  jump_taken =  Flags[2];
            3'b101:  jump_taken = !(Flags[2] ^ Flags[3]);
            3'b110:  jump_taken =  (Flags[2] ^ Flags[3]);
            default: jump_taken = 1'b1;
        endcase
    end

    // Alu_op 1 can only come from format-II SWPB, which leaves flags alone
    assign wb_wr    = !((Alu_op == 4'h9) || (Alu_op == 4'hB));
    assign wb_flags = !((Alu_op == 4'h4) || (Alu_op == 4'hC) ||
                        (Alu_op == 4'hD) || (Alu_op == 4'h1));

    assign Bw            = Instr[6];
    assign PC_offset_out = Instr[9:0];
    assign Fsm           = FSM_W'(state);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            cnt         <= '0;
            Instr       <= '0;
            Instr_1     <= '0;
            Src_reg_out <= '0;
            Dst_reg_out <= '0;
            Alu_op      <= '0;
            Imm_sel     <= 1'b0;
            Wr_en_out   <= 1'b0;
            Flags_wr    <= 1'b0;
            PC_inc_out  <= 1'b0;
            PC_load     <= 1'b0;
            Trap        <= 1'b0;
            mem.Mem_req <= 1'b0;
        end else begin
            PC_inc_out <= 1'b0;
            PC_load    <= 1'b0;
            Wr_en_out  <= 1'b0;
            Flags_wr   <= 1'b0;
            case (state)
                IDLE: begin
                    state       <= FETCH;
                    mem.Mem_req <= 1'b1;
                    cnt         <= '0;
                end
                // An ack arriving on the limit cycle still wins over the timeout
                FETCH, EXT: begin
                    if (mem.Mem_ack) begin
                        mem.Mem_req <= 1'b0;
                        PC_inc_out  <= 1'b1;
                        if (state == FETCH) begin
                            Instr <= mem.Mem_rdata;
                            state <= DECODE;
                        end else begin
                            Instr_1 <= mem.Mem_rdata;
                            Imm_sel <= 1'b1;
                            state   <= EXEC;
                        end
                    end else if (cnt >= CNT_LIMIT) begin
                        mem.Mem_req <= 1'b0;
                        Trap        <= 1'b1;
                        state       <= TRAP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DECODE: begin
                    if (is_jump) begin
                        PC_load <= jump_taken;
                        state   <= JUMP;
                    end else if (dec_legal) begin
                        Src_reg_out <= dec_src;
                        Dst_reg_out <= dec_dst;
                        Alu_op      <= dec_alu;
                        if (dec_imm) begin
                            mem.Mem_req <= 1'b1;
                            cnt         <= '0;
                            state       <= EXT;
                        end else begin
                            state <= EXEC;
                        end
                    end else begin
                        Trap  <= 1'b1;
                        state <= TRAP;
                    end
                end
                EXEC: begin
                    Wr_en_out <= wb_wr;
                    Flags_wr  <= wb_flags;
                    state     <= WB;
                end
                WB, JUMP: begin
                    Imm_sel     <= 1'b0;
                    mem.Mem_req <= (RETIRE == FETCH);
                    cnt         <= '0;
                    state       <= RETIRE;
                end
`ifdef SINGLE_STEP_EN
                STEP_WAIT: begin
                    if (Step) begin
                        mem.Mem_req <= 1'b1;
                        cnt         <= '0;
                        state       <= FETCH;
                    end
                end
`endif
                TRAP: begin
                    Trap        <= 1'b1;
                    mem.Mem_req <= 1'b0;
                end
                default: begin
                    Trap        <= 1'b1;
                    mem.Mem_req <= 1'b0;
                    state       <= TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msp430_ctrl_seq.sv
// Directed scoreboard bench for msp430_ctrl_seq; a responder task plays memory.
// Builds with or without SINGLE_STEP_EN.
`timescale 1ns/1ps
module tb_msp430_ctrl_seq;
    localparam int unsigned FSM_W       = 5;
    localparam int unsigned MEM_TIMEOUT = 15;
`ifdef SINGLE_STEP_EN
    localparam logic [4:0] RETIRE = 5'd8;
`else
    localparam logic [4:0] RETIRE = 5'd1;
`endif

    logic              Clk = 1'b0;
    logic              Rst;
    logic [3:0]        Flags;
    logic [15:0]       Instr, Instr_1;
    logic [3:0]        Src_reg_out, Dst_reg_out, Alu_op;
    logic              Bw, Imm_sel, Wr_en_out, Flags_wr, PC_inc_out, PC_load, Trap;
    logic [9:0]        PC_offset_out;
    logic [FSM_W-1:0]  Fsm;
`ifdef SINGLE_STEP_EN
    logic              Step;
`endif

    msp430_ctrl_seq_if mem_if();

    msp430_ctrl_seq #(.FSM_W(FSM_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .Clk(Clk),
        .Rst(Rst),
`ifdef SINGLE_STEP_EN
        .Step(Step),
`endif
        .mem(mem_if),
        .Flags(Flags),
        .Instr(Instr),
        .Instr_1(Instr_1),
        .Src_reg_out(Src_reg_out),
        .Dst_reg_out(Dst_reg_out),
        .Alu_op(Alu_op),
        .Bw(Bw),
        .Imm_sel(Imm_sel),
        .Wr_en_out(Wr_en_out),
        .Flags_wr(Flags_wr),
        .PC_inc_out(PC_inc_out),
        .PC_load(PC_load),
        .PC_offset_out(PC_offset_out),
        .Trap(Trap),
        .Fsm(Fsm)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  term;
        int          lat, pc_inc, wr, flg, pcl;
        logic        chk_regs, chk_i1, chk_off;
        logic [3:0]  src, dst, alu;
        logic        imm;
        logic [15:0] i1;
        logic [9:0]  off;
    } exp_t;

    typedef struct {
        logic [4:0]  term;
        int          lat, pc_inc, wr, flg, pcl, ntr;
        logic [3:0]  src, dst, alu;
        logic        imm;
        logic [15:0] i1;
        logic [9:0]  off;
        logic [34:0] trace;
    } obs_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   bad;
    obs_t o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Reference behaviour of one instruction given encoding, flags and ack delay
    function automatic exp_t model(input logic [15:0] w, input logic [15:0] ext,
                                   input logic [3:0] fl, input int d);
        exp_t e;
        logic v, n, z, c, taken;
        logic [1:0] as_;
        e = '{default: '0};
        {v, n, z, c} = fl;
        as_ = w[5:4];
        taken = 1'b0;
        e.term = 5'd7;
        if (d >= int'(MEM_TIMEOUT)) begin
            e.lat = int'(MEM_TIMEOUT);
            return e;
        end
        e.pc_inc = 1;
        e.lat    = d + 2;
        if (w[15:13] == 3'b001) begin
            case (w[12:10])
                3'd0: taken = !z;
                3'd1: taken = z;
                3'd2: taken = !c;
                3'd3: taken = c;
                3'd4: taken = n;
                3'd5: taken = !(n ^ v);
                3'd6: taken = n ^ v;
                default: taken = 1'b1;
            endcase
            e.term = RETIRE; e.lat += 1; e.pcl = taken ? 1 : 0;
            e.chk_off = 1'b1; e.off = w[9:0];
        end else if (w[15:12] >= 4'h4 && !w[7] &&
                     (as_ == 2'b00 || (as_ == 2'b11 && w[11:8] == 4'h0))) begin
            e.chk_regs = 1'b1; e.src = w[11:8]; e.dst = w[3:0]; e.alu = w[15:12];
            e.imm = (as_ == 2'b11);
            e.wr  = (e.alu == 4'h9 || e.alu == 4'hB) ? 0 : 1;
            e.flg = (e.alu == 4'h4 || e.alu == 4'hC || e.alu == 4'hD) ? 0 : 1;
            if (e.imm) begin
                e.pc_inc = 2; e.lat += d + 1; e.chk_i1 = 1'b1; e.i1 = ext;
            end
            e.lat += 2; e.term = RETIRE;
        end else if (w[15:10] == 6'b000100 && !w[9] && as_ == 2'b00) begin
            e.chk_regs = 1'b1; e.src = w[3:0]; e.dst = w[3:0]; e.alu = {2'b00, w[8:7]};
            e.wr = 1; e.flg = (w[8:7] == 2'b01) ? 0 : 1;
            e.lat += 2; e.term = RETIRE;
        end
        return e;
    endfunction

    // Plays memory (ack after d idle request cycles) and records DUT behaviour
    task automatic run(input logic [15:0] w, input logic [15:0] ext, input logic [3:0] fl,
                       input int d, output obs_t r);
        int waited, words;
        bit dec_seen, done;
        r = '{default: '0};
        waited = 0; words = 0; dec_seen = 1'b0; done = 1'b0;
        Flags = fl;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            if (r.ntr < 7) begin
                r.trace = {r.trace[29:0], Fsm};
                r.ntr++;
            end
            if (Fsm == 5'd7 || (dec_seen && (Fsm == 5'd1 || Fsm == 5'd8))) begin
                r.term = Fsm;
                done   = 1'b1;
            end else begin
                if (Fsm >= 5'd1 && Fsm <= 5'd6) r.lat++;
                if (Fsm == 5'd2) dec_seen = 1'b1;
                if (Fsm == 5'd4) begin
                    r.src = Src_reg_out; r.dst = Dst_reg_out; r.alu = Alu_op; r.imm = Imm_sel;
                end
                if (Fsm == 5'd6) r.off = PC_offset_out;
                if (PC_inc_out) r.pc_inc++;
                if (Wr_en_out)  r.wr++;
                if (Flags_wr)   r.flg++;
                if (PC_load)    r.pcl++;
                mem_if.Mem_ack = 1'b0;
                if (mem_if.Mem_req) begin
                    if (waited == d) begin
                        mem_if.Mem_ack   = 1'b1;
                        mem_if.Mem_rdata = (words == 0) ? w : ext;
                        words++;
                        waited = 0;
                    end else begin
                        waited++;
                    end
                end
                tick;
            end
        end
        mem_if.Mem_ack = 1'b0;
        r.i1 = Instr_1;
        check("run.completes", 32'(done), 32'd1);
    endtask

`ifdef SINGLE_STEP_EN
    task automatic step_release(input string name);
        int hold_bad;
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (Fsm !== 5'd8 || mem_if.Mem_req !== 1'b0) hold_bad++;
            tick;
        end
        check({name, ".step_hold"}, 32'(hold_bad), 32'd0);
        Step = 1'b1;
        tick;
        Step = 1'b0;
        check({name, ".step_go"}, 32'(Fsm), 32'd1);
    endtask
`endif

    task automatic do_instr(input string name, input logic [15:0] w, input logic [15:0] ext,
                            input logic [3:0] fl, input int d, output obs_t r);
        exp_t e;
        sb.push_back(model(w, ext, fl, d));
        run(w, ext, fl, d, r);
        e = sb.pop_front();
        check({name, ".term"},   32'(r.term),   32'(e.term));
        check({name, ".lat"},    32'(r.lat),    32'(e.lat));
        check({name, ".pc_inc"}, 32'(r.pc_inc), 32'(e.pc_inc));
        check({name, ".wr_en"},  32'(r.wr),     32'(e.wr));
        check({name, ".flg_wr"}, 32'(r.flg),    32'(e.flg));
        check({name, ".pc_ld"},  32'(r.pcl),    32'(e.pcl));
        check({name, ".trap"},   32'(Trap),     32'(e.term == 5'd7));
        if (e.chk_regs) begin
            check({name, ".src"}, 32'(r.src), 32'(e.src));
            check({name, ".dst"}, 32'(r.dst), 32'(e.dst));
            check({name, ".alu"}, 32'(r.alu), 32'(e.alu));
            check({name, ".imm"}, 32'(r.imm), 32'(e.imm));
        end
        if (e.chk_i1)  check({name, ".instr_1"}, 32'(r.i1),  32'(e.i1));
        if (e.chk_off) check({name, ".offset"},  32'(r.off), 32'(e.off));
`ifdef SINGLE_STEP_EN
        if (e.term == 5'd8) step_release(name);
`endif
    endtask

    task automatic do_reset;
        Rst = 1'b1;
        mem_if.Mem_ack = 1'b0;
        tick;
        tick;
        Rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [34:0] exp_tr;
        Rst = 1'b1; Flags = 4'h0; mem_if.Mem_ack = 1'b0; mem_if.Mem_rdata = 16'h0;
`ifdef SINGLE_STEP_EN
        Step = 1'b0;
`endif
        tick;
        tick;
        check("rst.fsm",     32'(Fsm), 32'd0);
        check("rst.instr",   32'(Instr), 32'd0);
        check("rst.instr_1", 32'(Instr_1), 32'd0);
        check("rst.trap",    32'(Trap), 32'd0);
        check("rst.mem_req", 32'(mem_if.Mem_req), 32'd0);
        check("rst.regs",    32'({Src_reg_out, Dst_reg_out, Alu_op, PC_offset_out}), 32'd0);
        check("rst.pulses",  32'({Wr_en_out, Flags_wr, PC_inc_out, PC_load, Imm_sel}), 32'd0);
        Rst = 1'b0;

        do_instr("add", 16'h5405, 16'h0, 4'h0, 1, o);
        exp_tr = {5'd0, 5'd1, 5'd1, 5'd2, 5'd4, 5'd5, RETIRE};
        checks++;
        assert (o.trace === exp_tr) else begin
            errors++;
            $error("FAIL add.fsm_trace: observed=%h expected=%h", o.trace, exp_tr);
        end

        do_instr("mov_imm",  16'h403A, 16'h1234, 4'h0, 1, o);
        do_instr("jeq_tk",   16'h2403, 16'h0, 4'b0010, 1, o);
        do_instr("jeq_nt",   16'h2403, 16'h0, 4'b0000, 1, o);
        do_instr("jmp_neg",  16'h3FFF, 16'h0, 4'b0000, 1, o);
        do_instr("jge_nv",   16'h3402, 16'h0, 4'b1100, 1, o);
        do_instr("cmp",      16'h9405, 16'h0, 4'h0, 1, o);
        do_instr("swpb",     16'h1085, 16'h0, 4'h0, 1, o);
        do_instr("ack_c14",  16'h5405, 16'h0, 4'h0, 13, o);
        do_instr("ack_c15",  16'hF10E, 16'h0, 4'h0, 14, o);
        do_instr("call",     16'h1285, 16'h0, 4'h0, 1, o);

        bad = 0;
        for (int i = 0; i < 6; i++) begin
            mem_if.Mem_ack   = i[0];
            mem_if.Mem_rdata = 16'h5405;
            tick;
            if (Fsm !== 5'd7 || Trap !== 1'b1 || mem_if.Mem_req !== 1'b0 ||
                Wr_en_out !== 1'b0 || PC_inc_out !== 1'b0) bad++;
        end
        mem_if.Mem_ack = 1'b0;
        check("trap.sticky", 32'(bad), 32'd0);

        do_reset;
        do_instr("timeout", 16'h5405, 16'h0, 4'h0, 100, o);
        do_reset;
        do_instr("ad_illegal", 16'h5485, 16'h0, 4'h0, 1, o);

        // Asynchronous abort, then a stale ack lingering through IDLE
        #3;
        Rst = 1'b1;
        #1;
        check("arst.fsm",     32'(Fsm), 32'd0);
        check("arst.trap",    32'(Trap), 32'd0);
        check("arst.mem_req", 32'(mem_if.Mem_req), 32'd0);
        mem_if.Mem_ack   = 1'b1;
        mem_if.Mem_rdata = 16'hFFFF;
        tick;
        Rst = 1'b0;
        tick;
        mem_if.Mem_ack = 1'b0;
        check("stale_ack.fsm",   32'(Fsm), 32'd1);
        check("stale_ack.instr", 32'(Instr), 32'd0);
        do_instr("post_rst", 16'h5405, 16'h0, 4'h0, 1, o);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
